// File: rtl/grid_scanner.sv
// Captures a full cell-array generation and streams it out one row per cycle, with live-cell count and frame status.
// Latency: capture on the gen_valid edge, first row offered the next cycle, frame_done ROWS cycles later at full rate.
// Backpressure: row_ready=0 holds row_data/row_idx; gen_valid arriving while a frame streams is dropped and flags overrun.
module grid_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ROWS*COLS-1:0]             live_grid,
  input  logic                             gen_valid,
  output logic [COLS-1:0]                  row_data,
  output logic [$clog2(ROWS)-1:0]          row_idx,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic                             row_last,
  output logic [$clog2(ROWS*COLS+1)-1:0]   pop_count,
  output logic [15:0]                      gen_count,
  output logic                             frame_done,
  output logic                             extinct,
  output logic                             still,
  output logic                             overrun
);

  localparam int IW = $clog2(ROWS);
  localparam int PW = $clog2(ROWS*COLS+1);
  localparam logic [IW-1:0] LAST_ROW = IW'(ROWS-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state, state_nxt;
  // The capture buffer is untouched between captures, so at the next capture
  // it still holds the previously captured frame and serves as that reference.
  logic [ROWS-1:0][COLS-1:0]  cap;
  logic                       first;
  logic [PW-1:0]              acc;
  logic [PW-1:0]              row_pop;
  logic [PW-1:0]              frame_total;
  logic                       capture, xfer, final_xfer;

  function automatic logic [PW-1:0] popc(input logic [COLS-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  // State register; reset forces IDLE, aborting any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus handshake/strobe decode.
  always_comb begin
    state_nxt  = state;
    row_valid  = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    final_xfer = 1'b0;
    case (state)
      IDLE: begin
        if (gen_valid) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        row_valid = 1'b1;
        if (row_ready) begin
          xfer = 1'b1;
          if (row_idx == LAST_ROW) begin
            final_xfer = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign row_data    = row_valid ? cap[row_idx] : '0;
  assign row_last    = row_valid && (row_idx == LAST_ROW);
  assign row_pop     = popc(row_data);
  assign frame_total = acc + row_pop;

  // Capture, row advance, accumulation and frame status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap        <= '0;
      first      <= 1'b1;
      acc        <= '0;
      row_idx    <= '0;
      pop_count  <= '0;
      gen_count  <= '0;
      frame_done <= 1'b0;
      extinct    <= 1'b0;
      still      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        cap       <= live_grid;
        gen_count <= gen_count + 16'd1;
        row_idx   <= '0;
        acc       <= '0;
        still     <= !first && (live_grid == cap);
        first     <= 1'b0;
      end
      if (gen_valid && state == STREAM) overrun <= 1'b1;
      if (xfer) begin
        if (final_xfer) begin
          pop_count  <= frame_total;
          extinct    <= (frame_total == '0);
          frame_done <= 1'b1;
          row_idx    <= '0;
          acc        <= '0;
        end else begin
          row_idx <= row_idx + 1'b1;
          acc     <= frame_total;
        end
      end
    end
  end

endmodule
